// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op and state encodings, iteration count and a magnitude helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mduOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } mduState_t;

    localparam int unsigned ITERATIONS = 32;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic signedOp);
        return (signedOp && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// Exposes the next-step quotient/remainder so the final step can be captured directly.
module mdu_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividendMag,
    input  logic [31:0] divisorMag,
    output logic [31:0] quotNext,
    output logic [31:0] remNext
);

    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, divisor};
        quotNext = {quo[30:0], ~diff[32]};
        remNext  = diff[32] ? shifted[31:0] : diff[31:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
        end else if (start) begin
            quo     <= dividendMag;
            rem     <= '0;
            divisor <= divisorMag;
        end else if (step) begin
            quo <= quotNext;
            rem <= remNext;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MIPS HI/LO multiply/divide unit: 32-cycle shift-add multiply,
// 32-cycle restoring divide, MTHI/MTLO writes, stall handshake via MDUReadyE.
module mdu_iterative
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        MDUStartE,
    input  logic [1:0]  MDUOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        HIWriteE,
    input  logic        LOWriteE,
    output logic [31:0] HIOut,
    output logic [31:0] LOOut,
    output logic        MDUReadyE
);

    mduState_t   state;
    mduOp_t      opReg;
    logic [5:0]  iterCount;
    logic [31:0] mcand;
    logic [63:0] prod;
    logic        signA;
    logic        signB;
    logic [31:0] hiReg;
    logic [31:0] loReg;

    logic        signedOpIn;
    logic [31:0] magA;
    logic [31:0] magB;
    logic        lastIter;
    logic [32:0] partialSum;
    logic [63:0] prodNext;
    logic [63:0] mulResult;
    logic [31:0] quotNext;
    logic [31:0] remNext;
    logic [31:0] quotResult;
    logic [31:0] remResult;
    logic        divStart;

    always_comb begin
        signedOpIn = ~MDUOpE[0];
        magA       = magnitude(SrcAE, signedOpIn);
        magB       = magnitude(SrcBE, signedOpIn);
        divStart   = (state == IDLE) && MDUStartE && MDUOpE[1];
        lastIter   = (iterCount == 6'(ITERATIONS - 1));
    end

    // Shift-add: the low half of prod starts as the multiplier and drains out as
    // product bits shift in from the top.
    always_comb begin
        partialSum = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? mcand : 32'd0)};
        prodNext   = {partialSum, prod[31:1]};
        mulResult  = ((opReg == OP_MULT) && (signA ^ signB)) ? (~prodNext + 64'd1) : prodNext;
    end

    mdu_divider u_divider (
        .clk        (clk),
        .resetn     (resetn),
        .start      (divStart),
        .step       (state == DIV),
        .dividendMag(magA),
        .divisorMag (magB),
        .quotNext   (quotNext),
        .remNext    (remNext)
    );

    always_comb begin
        quotResult = quotNext;
        remResult  = remNext;
        if (opReg == OP_DIV) begin
            if (signA ^ signB) quotResult = ~quotNext + 32'd1;
            if (signA)         remResult  = ~remNext + 32'd1;
        end
    end

    always_comb begin
        case (state)
            IDLE:    MDUReadyE = ~MDUStartE;
            DONE:    MDUReadyE = 1'b1;
            default: MDUReadyE = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            opReg     <= OP_MULT;
            iterCount <= '0;
            mcand     <= '0;
            prod      <= '0;
            signA     <= 1'b0;
            signB     <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MDUStartE) begin
                        opReg     <= mduOp_t'(MDUOpE);
                        signA     <= signedOpIn & SrcAE[31];
                        signB     <= signedOpIn & SrcBE[31];
                        mcand     <= magA;
                        prod      <= {32'd0, magB};
                        iterCount <= '0;
                        state     <= MDUOpE[1] ? DIV : MUL;
                    end else begin
                        if (HIWriteE) hiReg <= SrcAE;
                        if (LOWriteE) loReg <= SrcAE;
                    end
                end
                MUL: begin
                    prod      <= prodNext;
                    iterCount <= iterCount + 6'd1;
                    if (lastIter) begin
                        hiReg <= mulResult[63:32];
                        loReg <= mulResult[31:0];
                        state <= DONE;
                    end
                end
                DIV: begin
                    iterCount <= iterCount + 6'd1;
                    if (lastIter) begin
                        hiReg <= remResult;
                        loReg <= quotResult;
                        state <= DONE;
                    end
                end
                DONE: begin
                    iterCount <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HIOut = hiReg;
    assign LOOut = loReg;

endmodule
